alarm_siren_ctrl: RTL and testbench
===================================

// Module: alarm_siren_ctrl
// PURPOSE
//   Sequential stage directly downstream of the combinational alarm/secure
//   evaluator. Consumes its alarm and secure outputs plus alarm_set. Adds exit
//   delay, entry delay, timed siren and a latched trip indicator. Drives the
//   siren and status outputs.
// PARAMETERS
//   EXIT_CYCLES   16  cycles in EXIT_DELAY before arming (>=1)
//   ENTRY_CYCLES   8  cycles of grace after a trip before the siren sounds (>=1)
//   SIREN_CYCLES  32  cycles the siren sounds before auto-silence (>=1)
//   CNT_W          8  delay counter width; must hold max(*_CYCLES)-1
// PORTS
//   clk            in   1  system clock, rising edge
//   reset          in   1  synchronous, active-high reset
//   alarm_set      in   1  arm request; 0 = disarm (highest priority)
//   alarm          in   1  trip condition from the evaluator stage
//   secure         in   1  all-closed indication from the evaluator stage
//   ack            in   1  clears the tripped latch; honoured only in DISARMED
//   armed          out  1  1 in ARMED, ENTRY_DELAY, SOUNDING, SILENCED
//   exit_pending   out  1  1 in EXIT_DELAY
//   entry_pending  out  1  1 in ENTRY_DELAY
//   siren          out  1  1 in SOUNDING only
//   tripped        out  1  sticky; set on entry to SOUNDING
//   beep           out  1  delay chirp (see CONFIGURATION)
// BEHAVIOUR
//   - All outputs are registered or decoded from registered state.
//   - Reset: state=DISARMED, cnt=0, alarm_q=0. Outputs armed, exit_pending,
//     entry_pending, siren, tripped and beep are all 0.
//   - Reset asserted mid-operation returns to DISARMED on the next edge and
//     clears tripped.
//   - Delay rule: entering a timed state loads cnt=N-1. cnt decrements each
//     cycle. The state exits on the cycle cnt==0, so it lasts exactly N cycles.
//   - alarm_q = alarm registered each cycle. rise = alarm & ~alarm_q.
//   - Global rule, checked before all others: alarm_set==0 in any state except
//     DISARMED -> DISARMED next cycle. siren drops on that same edge.
//   - DISARMED:    alarm_set=1 -> EXIT_DELAY, load EXIT_CYCLES-1.
//                  ack=1 clears tripped. ack is ignored in every other state.
//   - EXIT_DELAY:  alarm is ignored.
//                  At cnt==0 with secure=1 -> ARMED.
//                  At cnt==0 with secure=0 -> reload EXIT_CYCLES-1 and stay.
//   - ARMED:       alarm=1 (level) -> ENTRY_DELAY, load ENTRY_CYCLES-1.
//   - ENTRY_DELAY: alarm returning to 0 does not cancel the delay.
//                  At cnt==0 -> SOUNDING, load SIREN_CYCLES-1, set tripped.
//   - SOUNDING:    at cnt==0 -> SILENCED.
//   - SILENCED:    siren=0 and tripped stays 1.
//                  rise -> SOUNDING directly (no entry delay), reload
//                  SIREN_CYCLES-1. A held alarm level does not retrigger.
//   - Simultaneous events: alarm_set=0 together with cnt==0 or rise -> the
//     disarm wins.
//   - cnt never wraps. In untimed states cnt holds 0.
// CONFIGURATION
//   ALARM_CHIRP_EN defined: beep = ~cnt[0] while in EXIT_DELAY or ENTRY_DELAY,
//     0 otherwise. This gives a 1-on/1-off chirp starting high on the first
//     cycle of the delay when N-1 is even.
//   ALARM_CHIRP_EN undefined: beep is tied to 0. The port is still present and
//     no chirp logic is synthesised.
// TESTING
//   1. Reset 3 cycles, then release -> all outputs 0. Assert ack -> tripped
//      stays 0.
//   2. alarm_set=1, secure=1 held -> exit_pending for 16 cycles, then armed=1
//      on cycle 17.
//   3. Armed, pulse alarm 1 cycle -> entry_pending for 8 cycles. siren=1 for
//      32 cycles, then siren=0 with tripped=1. Drop alarm_set, then ack=1 ->
//      tripped=0.
//   4. alarm_set=1, secure=0 at exit expiry -> exit_pending stays 1 and the
//      delay restarts. secure=1 -> armed after 16 more cycles.
//   5. SILENCED: alarm held high -> no retrigger. Drop alarm for 1 cycle,
//      raise again -> siren=1 the following cycle for 32 cycles.
//   6. alarm_set=0 on the cycle the entry cnt==0 -> DISARMED and siren never
//      asserts. Reset mid-SOUNDING -> siren=0 and tripped=0 next cycle.
//      Check beep with and without ALARM_CHIRP_EN.

Source files
------------

// File: rtl/alarm_siren_ctrl.sv
// Alarm sequencer: exit delay, entry delay, timed siren and a sticky trip latch.
// Optional delay chirp on beep is enabled by defining ALARM_CHIRP_EN.
module alarm_siren_ctrl #(
  parameter int unsigned EXIT_CYCLES  = 16,
  parameter int unsigned ENTRY_CYCLES = 8,
  parameter int unsigned SIREN_CYCLES = 32,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic alarm_set,
  input  logic alarm,
  input  logic secure,
  input  logic ack,
  output logic armed,
  output logic exit_pending,
  output logic entry_pending,
  output logic siren,
  output logic tripped,
  output logic beep
);

  typedef enum logic [2:0] {
    StDisarmed,
    StExitDelay,
    StArmed,
    StEntryDelay,
    StSounding,
    StSilenced
  } state_e;

  localparam logic [CNT_W-1:0] ExitLoad  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] EntryLoad = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SirenLoad = CNT_W'(SIREN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q;
  logic             tripped_d;
  logic             rise;
  logic             cnt_zero;

  assign rise     = alarm & ~alarm_q;
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    tripped_d = tripped;
    // Disarm outranks every timer expiry and alarm edge.
    if (state_q != StDisarmed && !alarm_set) begin
      state_d = StDisarmed;
    end else begin
      unique case (state_q)
        StDisarmed: begin
          if (ack) tripped_d = 1'b0;
          if (alarm_set) begin
            state_d = StExitDelay;
            cnt_d   = ExitLoad;
          end
        end
        StExitDelay: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else if (secure) begin
            state_d = StArmed;
          end else begin
            cnt_d = ExitLoad;
          end
        end
        StArmed: begin
          if (alarm) begin
            state_d = StEntryDelay;
            cnt_d   = EntryLoad;
          end
        end
        StEntryDelay: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d   = StSounding;
            cnt_d     = SirenLoad;
            tripped_d = 1'b1;
          end
        end
        StSounding: begin
          if (!cnt_zero) cnt_d = cnt_q - 1'b1;
          else           state_d = StSilenced;
        end
        StSilenced: begin
          if (rise) begin
            state_d = StSounding;
            cnt_d   = SirenLoad;
          end
        end
        default: state_d = StDisarmed;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StDisarmed;
      cnt_q         <= '0;
      alarm_q       <= 1'b0;
      tripped       <= 1'b0;
      armed         <= 1'b0;
      exit_pending  <= 1'b0;
      entry_pending <= 1'b0;
      siren         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alarm_q       <= alarm;
      tripped       <= tripped_d;
      armed         <= (state_d == StArmed) || (state_d == StEntryDelay) ||
                       (state_d == StSounding) || (state_d == StSilenced);
      exit_pending  <= (state_d == StExitDelay);
      entry_pending <= (state_d == StEntryDelay);
      siren         <= (state_d == StSounding);
    end
  end

`ifdef ALARM_CHIRP_EN
  always_ff @(posedge clk) begin
    if (reset) beep <= 1'b0;
    else       beep <= ((state_d == StExitDelay) || (state_d == StEntryDelay)) & ~cnt_d[0];
  end
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Directed bench for alarm_siren_ctrl; status vector is
// {armed, exit_pending, entry_pending, siren, tripped, beep}.
module tb_alarm_siren_ctrl;

`ifdef ALARM_CHIRP_EN
  localparam bit Chirp = 1'b1;
`else
  localparam bit Chirp = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, alarm_set, alarm, secure, ack;
  logic armed, exit_pending, entry_pending, siren, tripped, beep;
  logic [5:0] st;
  int n_tests = 0;
  int n_fail  = 0;

  assign st = {armed, exit_pending, entry_pending, siren, tripped, beep};

  always #5 clk = ~clk;

  alarm_siren_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .alarm_set    (alarm_set),
    .alarm        (alarm),
    .secure       (secure),
    .ack          (ack),
    .armed        (armed),
    .exit_pending (exit_pending),
    .entry_pending(entry_pending),
    .siren        (siren),
    .tripped      (tripped),
    .beep         (beep)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; alarm_set = 1'b0; alarm = 1'b0; secure = 1'b0; ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (st !== 6'b000000) begin
      n_fail++; $display("FAIL reset_state got=%b exp=%b", st, 6'b000000);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_tests++;
    if (st !== 6'b000000) begin
      n_fail++; $display("FAIL reset_ack got=%b exp=%b", st, 6'b000000);
    end
  endtask

  task automatic test_exit_delay();
    logic [5:0] exp;
    int errs = 0;
    alarm_set = 1'b1; secure = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      // cnt after the k-th edge is 16-k
      exp = {5'b01000, Chirp & ~(k[0] ^ 1'b0) ? 1'b0 : Chirp};
      exp[0] = Chirp & ((16 - k) % 2 == 0);
      if (st !== exp) begin
        errs++; $display("FAIL exit_delay k=%0d got=%b exp=%b", k, st, exp);
      end
    end
    n_tests++;
    if (errs != 0) n_fail++;
    tick();
    n_tests++;
    if (st !== 6'b100000) begin
      n_fail++; $display("FAIL exit_to_armed got=%b exp=%b", st, 6'b100000);
    end
  endtask

  task automatic test_trip_cycle();
    logic [5:0] exp;
    int errs = 0;
    alarm = 1'b1;
    tick();
    alarm = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      exp = 6'b101000;
      exp[0] = Chirp & ((8 - k) % 2 == 0);
      if (st !== exp) begin
        errs++; $display("FAIL entry_delay k=%0d got=%b exp=%b", k, st, exp);
      end
    end
    n_tests++;
    if (errs != 0) n_fail++;
    errs = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (st !== 6'b100110) begin
        errs++; $display("FAIL sounding k=%0d got=%b exp=%b", k, st, 6'b100110);
      end
    end
    n_tests++;
    if (errs != 0) n_fail++;
    tick();
    n_tests++;
    if (st !== 6'b100010) begin
      n_fail++; $display("FAIL silenced got=%b exp=%b", st, 6'b100010);
    end
    alarm_set = 1'b0;
    tick();
    n_tests++;
    if (st !== 6'b000010) begin
      n_fail++; $display("FAIL disarm_keeps_trip got=%b exp=%b", st, 6'b000010);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_tests++;
    if (st !== 6'b000000) begin
      n_fail++; $display("FAIL ack_clears got=%b exp=%b", st, 6'b000000);
    end
  endtask

  task automatic test_exit_restart();
    alarm_set = 1'b1; secure = 1'b0;
    repeat (17) tick();
    n_tests++;
    if ({armed, exit_pending} !== 2'b01) begin
      n_fail++; $display("FAIL exit_restart got=%b exp=%b", {armed, exit_pending}, 2'b01);
    end
    secure = 1'b1;
    repeat (15) tick();
    n_tests++;
    if ({armed, exit_pending} !== 2'b01) begin
      n_fail++; $display("FAIL exit_restart_hold got=%b exp=%b", {armed, exit_pending}, 2'b01);
    end
    tick();
    n_tests++;
    if ({armed, exit_pending} !== 2'b10) begin
      n_fail++; $display("FAIL exit_restart_arm got=%b exp=%b", {armed, exit_pending}, 2'b10);
    end
  endtask

  task automatic test_silenced_retrigger();
    int errs = 0;
    alarm = 1'b1;
    repeat (41) tick();
    n_tests++;
    if (st !== 6'b100010) begin
      n_fail++; $display("FAIL held_silenced got=%b exp=%b", st, 6'b100010);
    end
    repeat (3) tick();
    n_tests++;
    if (siren !== 1'b0) begin
      n_fail++; $display("FAIL held_no_retrigger got=%b exp=%b", siren, 1'b0);
    end
    alarm = 1'b0;
    tick();
    alarm = 1'b1;
    tick();
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) tick();
      if (st !== 6'b100110) begin
        errs++; $display("FAIL retrigger k=%0d got=%b exp=%b", k, st, 6'b100110);
      end
    end
    n_tests++;
    if (errs != 0) n_fail++;
    tick();
    n_tests++;
    if (st !== 6'b100010) begin
      n_fail++; $display("FAIL retrigger_end got=%b exp=%b", st, 6'b100010);
    end
    alarm = 1'b0; alarm_set = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_disarm_race_and_reset();
    alarm_set = 1'b1; secure = 1'b1;
    repeat (17) tick();
    alarm = 1'b1;
    tick();
    alarm = 1'b0;
    repeat (7) tick();
    n_tests++;
    if (st[5:2] !== 4'b1010) begin
      n_fail++; $display("FAIL race_pre got=%b exp=%b", st[5:2], 4'b1010);
    end
    alarm_set = 1'b0;
    tick();
    n_tests++;
    if (st !== 6'b000000) begin
      n_fail++; $display("FAIL race_disarm got=%b exp=%b", st, 6'b000000);
    end
    alarm_set = 1'b1;
    repeat (17) tick();
    alarm = 1'b1;
    tick();
    alarm = 1'b0;
    repeat (10) tick();
    n_tests++;
    if (st !== 6'b100110) begin
      n_fail++; $display("FAIL pre_reset_sounding got=%b exp=%b", st, 6'b100110);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; alarm_set = 1'b0;
    n_tests++;
    if (st !== 6'b000000) begin
      n_fail++; $display("FAIL reset_mid_sounding got=%b exp=%b", st, 6'b000000);
    end
  endtask

  initial begin
    test_reset();
    test_exit_delay();
    test_trip_cycle();
    test_exit_restart();
    test_silenced_retrigger();
    test_disarm_race_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
